// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment driver for a 16-bit value, shown in decimal
// (sequential double-dabble) or hex, with optional leading-zero blanking.
module seg7_scan_display #(
  parameter int CLK_DIV_BITS = 17,
  parameter int DIGITS       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       value,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  output logic              busy,
  output logic [DIGITS-1:0] digit_sel,
  output logic [7:0]        seg
);

  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [15:0]       bin;
  logic [19:0]       bcd;
  logic [19:0]       bcd_adj;
  logic              conv_hex;

  logic [4:0][3:0]   disp_buf;
  logic              disp_hex;

  logic [CLK_DIV_BITS-1:0] div;
  logic [IDX_W-1:0]        index;

  logic [3:0]        cur_digit;
  logic              cur_shown;
  logic              cur_zero_up;
  logic [7:0]        seg_next;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 8'hC0;
      4'h1: decode = 8'hF9;
      4'h2: decode = 8'hA4;
      4'h3: decode = 8'hB0;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h92;
      4'h6: decode = 8'h82;
      4'h7: decode = 8'hF8;
      4'h8: decode = 8'h80;
      4'h9: decode = 8'h90;
      4'hA: decode = 8'h88;
      4'hB: decode = 8'h83;
      4'hC: decode = 8'hC6;
      4'hD: decode = 8'hA1;
      4'hE: decode = 8'h86;
      default: decode = 8'h8E;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 5; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  // NOTE: non-blocking assignments throughout, so each SHIFT edge reads the previous bcd/bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bit_cnt  <= 4'd0;
      bin      <= 16'd0;
      bcd      <= 20'd0;
      conv_hex <= 1'b0;
      disp_buf <= '0;
      disp_hex <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            bin      <= value;
            conv_hex <= hex_mode;
            bcd      <= 20'd0;
            bit_cnt  <= 4'd0;
            busy     <= 1'b1;
            state    <= hex_mode ? COMMIT : SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj[18:0], bin[15]};
          bin     <= {bin[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          // The only place the display buffer changes, so the scan never sees partial results.
          disp_buf <= conv_hex ? {4'h0, bin} : bcd;
          disp_hex <= conv_hex;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, which rules out latches.
  always_comb begin
    cur_digit   = 4'd0;
    cur_shown   = 1'b0;
    cur_zero_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (index == IDX_W'(i)) begin
        cur_digit = disp_buf[i];
        cur_shown = (i < 4) || !disp_hex;
      end
      if (IDX_W'(i) >= index && disp_buf[i] != 4'd0) cur_zero_up = 1'b0;
    end
    if (!cur_shown || (blank_lz && index != '0 && cur_zero_up)) seg_next = 8'hFF;
    else                                                          seg_next = decode(cur_digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      index     <= '0;
      digit_sel <= '1;
      seg       <= 8'hFF;
    end else begin
      div <= div + 1'b1;
      if (&div) index <= (index == IDX_W'(DIGITS - 1)) ? '0 : index + 1'b1;
      digit_sel <= ~(DIGITS'(1) << index);
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with a fast scan divider; expected
// digits come from plain division/modulo on the loaded value.
module tb_seg7_scan_display;

  localparam int DIV_BITS = 2;
  localparam int DIGITS   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       value = 16'd0;
  logic              load = 1'b0;
  logic              hex_mode = 1'b0;
  logic              blank_lz = 1'b0;
  logic              busy;
  logic [DIGITS-1:0] digit_sel;
  logic [7:0]        seg;

  seg7_scan_display #(.CLK_DIV_BITS(DIV_BITS), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy), .digit_sel(digit_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_value = 16'd0;
  logic        m_hex   = 1'b0;

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Expected pattern for digit idx: the idx-th base-10/base-16 digit of v, blanked when
  // beyond the shown width or when it and everything above it are zero.
  function automatic logic [7:0] model_seg(input int idx, input logic [15:0] v,
                                           input logic hx, input logic lz);
    int base = hx ? 16 : 10;
    int ndig = hx ? 4 : 5;
    int p    = 1;
    int iv   = int'(v);
    if (idx >= ndig) return 8'hFF;
    for (int k = 0; k < idx; k++) p = p * base;
    if (lz && idx > 0 && (iv / p) == 0) return 8'hFF;
    return seg_lut[(iv / p) % base];
  endfunction

  task automatic apply_load(input logic [15:0] v, input logic hx);
    @(negedge clk);
    value    = v;
    hex_mode = hx;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    tests++;
    if (cycles >= 200) begin
      fails++;
      $display("FAIL %s busy_timeout got busy=%b after %0d cycles want 0", tag, busy, cycles);
    end
  endtask

  task automatic scan_compare(input string tag);
    int idx;
    int zeros;
    logic [7:0] exp;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      idx   = -1;
      zeros = 0;
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_sel[i] !== 1'b1) begin
          zeros++;
          idx = i;
        end
      end
      tests++;
      if (zeros != 1) begin
        fails++;
        $display("FAIL %s onehot digit_sel got %b want exactly one zero", tag, digit_sel);
      end else begin
        exp = model_seg(idx, m_value, m_hex, blank_lz);
        tests++;
        if (seg !== exp) begin
          fails++;
          $display("FAIL %s digit%0d seg got %h want %h (value=%0d hex=%b lz=%b)",
                   tag, idx, seg, exp, m_value, m_hex, blank_lz);
        end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || seg !== 8'hFF || digit_sel !== 8'hFF) begin
      fails++;
      $display("FAIL reset_state got busy=%b seg=%h sel=%h want 0 FF FF", busy, seg, digit_sel);
    end
  endtask

  task automatic test_scan;
    logic [7:0] exp;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      exp = ~(8'b1 << (((k - 1) / 4) % 8));
      tests++;
      if (digit_sel !== exp) begin
        fails++;
        $display("FAIL scan_step edge%0d digit_sel got %b want %b", k, digit_sel, exp);
      end
    end
  endtask

  task automatic test_decimal;
    int cyc;
    blank_lz = 1'b1;
    apply_load(16'd12345, 1'b0);
    m_value = 16'd12345;
    m_hex   = 1'b0;
    wait_idle("dec_12345", cyc);
    tests++;
    if (cyc != 17) begin
      fails++;
      $display("FAIL dec_busy_width got %0d want 17", cyc);
    end
    scan_compare("dec_12345");
  endtask

  task automatic test_hex;
    int cyc;
    apply_load(16'hBEEF, 1'b1);
    m_value = 16'hBEEF;
    m_hex   = 1'b1;
    wait_idle("hex_beef", cyc);
    tests++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL hex_busy_width got %0d want 1", cyc);
    end
    scan_compare("hex_beef");
  endtask

  task automatic test_reset_async;
    int cyc;
    apply_load(16'd4321, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || seg !== 8'hFF || digit_sel !== 8'hFF) begin
      fails++;
      $display("FAIL async_reset got busy=%b seg=%h sel=%h want 0 FF FF", busy, seg, digit_sel);
    end
    @(negedge clk);
    rst     = 1'b0;
    m_value = 16'd0;
    m_hex   = 1'b0;
    wait_idle("post_reset", cyc);
    scan_compare("post_reset");
  endtask

  task automatic test_boundaries;
    int cyc;
    blank_lz = 1'b1;
    apply_load(16'd0, 1'b0);
    m_value = 16'd0;
    m_hex   = 1'b0;
    wait_idle("zero", cyc);
    scan_compare("zero_lz1");
    blank_lz = 1'b0;
    scan_compare("zero_lz0");
    blank_lz = 1'b1;
    apply_load(16'd65535, 1'b0);
    m_value = 16'd65535;
    wait_idle("max", cyc);
    scan_compare("max_65535");
    apply_load(16'd1005, 1'b0);
    m_value = 16'd1005;
    wait_idle("v1005", cyc);
    scan_compare("v1005_lz1");
    blank_lz = 1'b0;
    scan_compare("v1005_lz0");
    blank_lz = 1'b1;
    apply_load(16'h00A0, 1'b1);
    m_value = 16'h00A0;
    m_hex   = 1'b1;
    wait_idle("hex_a0", cyc);
    scan_compare("hex_00a0");
  endtask

  task automatic test_back_to_back;
    int cyc;
    blank_lz = 1'b1;
    apply_load(16'd7, 1'b0);
    m_value = 16'd7;
    m_hex   = 1'b0;
    repeat (4) @(negedge clk);
    value = 16'd9;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle("drop_9", cyc);
    scan_compare("drop_9");

    // Load presented in the cycle busy falls must be ignored.
    apply_load(16'hBEEF, 1'b1);
    m_value  = 16'hBEEF;
    m_hex    = 1'b1;
    value    = 16'h1234;
    hex_mode = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL load_on_fall busy got %b want 0", busy);
    end
    scan_compare("load_on_fall");

    apply_load(16'd54321, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort busy got %b want 0", busy);
    end
    @(negedge clk);
    rst     = 1'b0;
    m_value = 16'd0;
    m_hex   = 1'b0;
    scan_compare("abort");
  endtask

  task automatic test_random;
    int cyc;
    logic [15:0] v;
    logic hx;
    for (int r = 0; r < 8; r++) begin
      v        = (r % 3 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
      hx       = 1'($urandom % 2);
      blank_lz = 1'($urandom % 2);
      apply_load(v, hx);
      m_value = v;
      m_hex   = hx;
      wait_idle("random", cyc);
      tests++;
      if (cyc != (hx ? 1 : 17)) begin
        fails++;
        $display("FAIL random_busy_width got %0d want %0d", cyc, hx ? 1 : 17);
      end
      scan_compare("random");
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_decimal;
    test_hex;
    test_reset_async;
    test_boundaries;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
